// File: rtl/accum_seq_pkg.sv
// Shared types and default sizes for the series-sum arbiter.
package accum_seq_pkg;

   localparam int ACC_WIDTH = 6;
   localparam int ACC_CNT_W = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/accum_datapath.sv
// Running-sum datapath: W <= W + B, B <= B + 1, with carry out of W + B.
module accum_datapath
   import accum_seq_pkg::*;
#(
   parameter int WIDTH = ACC_WIDTH,
   parameter int CNT_W = ACC_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr_i,
   input  logic             cnt_i,
   input  logic             load_w_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             carry_o
);

   logic [WIDTH-1:0] w_q;
   logic [CNT_W-1:0] b_q;
   logic [WIDTH:0]   s_full;

   assign s_full  = {1'b0, w_q} + (WIDTH+1)'(b_q);
   assign sum_o   = s_full[WIDTH-1:0];
   assign carry_o = s_full[WIDTH];

   always_ff @(posedge clk) begin
      if (reset || clr_i) begin
         w_q <= '0;
         b_q <= '0;
      end else begin
         if (load_w_i) w_q <= s_full[WIDTH-1:0];
         if (cnt_i)    b_q <= b_q + 1'b1;
      end
   end

endmodule

// File: rtl/accum_seq_arbiter.sv
// Two-requester arbiter and sequencer for the shared running-sum datapath.
// state | meaning
// IDLE  | no grant; pick a winner, latch its step count, clear datapath
// RUN   | one accumulation step per cycle until the step count expires
// DONE  | result/overflow valid, done pulses, pointer moves to other requester
module accum_seq_arbiter
   import accum_seq_pkg::*;
#(
   parameter int WIDTH = ACC_WIDTH,
   parameter int CNT_W = ACC_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       req,
   input  logic [CNT_W-1:0] n0,
   input  logic [CNT_W-1:0] n1,
   output logic [1:0]       gnt,
   output logic             busy,
   output logic             done,
   output logic             done_id,
   output logic [WIDTH-1:0] result,
   output logic             overflow
);

   state_t           state_q, state_d;
   logic             ptr_q, ptr_d;
   logic             winner_q, winner_d;
   logic [CNT_W-1:0] n_lat_q, n_lat_d;
   logic             ovf_acc_q, ovf_acc_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             overflow_q, overflow_d;
   logic             pick;
   logic [CNT_W-1:0] sel_n;
   logic             dp_clr, dp_step, dp_carry;
   logic [WIDTH-1:0] dp_sum;

   accum_datapath #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dp (
      .clk      (clk),
      .reset    (reset),
      .clr_i    (dp_clr),
      .cnt_i    (dp_step),
      .load_w_i (dp_step),
      .sum_o    (dp_sum),
      .carry_o  (dp_carry)
   );

   assign pick  = (req == 2'b11) ? ptr_q : req[1];
   assign sel_n = pick ? n1 : n0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         ptr_q      <= 1'b0;
         winner_q   <= 1'b0;
         n_lat_q    <= '0;
         ovf_acc_q  <= 1'b0;
         result_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         winner_q   <= winner_d;
         n_lat_q    <= n_lat_d;
         ovf_acc_q  <= ovf_acc_d;
         result_q   <= result_d;
         overflow_q <= overflow_d;
      end
   end

   // n_lat_q counts down the remaining RUN steps; terminal count is 1.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      winner_d   = winner_q;
      n_lat_d    = n_lat_q;
      ovf_acc_d  = ovf_acc_q;
      result_d   = result_q;
      overflow_d = overflow_q;
      dp_clr     = 1'b0;
      dp_step    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req != 2'b00) begin
               winner_d  = pick;
               n_lat_d   = sel_n;
               ovf_acc_d = 1'b0;
               dp_clr    = 1'b1;
               if (sel_n == '0) begin
                  state_d    = DONE;
                  result_d   = '0;
                  overflow_d = 1'b0;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            dp_step   = 1'b1;
            ovf_acc_d = ovf_acc_q | dp_carry;
            n_lat_d   = n_lat_q - 1'b1;
            if (n_lat_q == CNT_W'(1)) begin
               state_d    = DONE;
               result_d   = dp_sum;
               overflow_d = ovf_acc_q | dp_carry;
            end
         end
         DONE: begin
            ptr_d   = ~winner_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy     = (state_q != IDLE);
   assign gnt      = busy ? (winner_q ? 2'b10 : 2'b01) : 2'b00;
   assign done     = (state_q == DONE);
   assign done_id  = winner_q;
   assign result   = result_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_accum_seq_arbiter.sv
// Directed bench for accum_seq_arbiter: vector table plus multi-cycle sequences.
module tb_accum_seq_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] req;
   logic [4:0] n0, n1;
   logic [1:0] gnt;
   logic       busy, done, done_id, overflow;
   logic [5:0] result;

   int tests = 0;
   int fails = 0;

   accum_seq_arbiter dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .n0       (n0),
      .n1       (n1),
      .gnt      (gnt),
      .busy     (busy),
      .done     (done),
      .done_id  (done_id),
      .result   (result),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] req;
      logic [4:0] n0;
      logic [4:0] n1;
      logic       exp_id;
      logic [5:0] exp_res;
      logic       exp_ovf;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      req   = 2'b00;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Starts one operation, checks grant every cycle, latency, result, then idle.
   task automatic run_op(input string name, input logic [1:0] r, input logic [4:0] a,
                         input logic [4:0] b, input logic exp_id, input logic [5:0] exp_res,
                         input logic exp_ovf);
      logic [1:0] exp_gnt;
      int         lat;
      int         nexp;
      bit         got;
      exp_gnt = exp_id ? 2'b10 : 2'b01;
      nexp    = exp_id ? int'(b) : int'(a);
      got     = 1'b0;
      lat     = 0;
      @(negedge clk);
      req = r;
      n0  = a;
      n1  = b;
      for (int k = 1; k <= 40 && !got; k++) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            lat = k;
         end else begin
            chk({name, " gnt_run"}, gnt, exp_gnt);
         end
      end
      chk({name, " done_seen"}, got, 1);
      chk({name, " latency"}, lat, nexp + 1);
      chk({name, " done_id"}, done_id, exp_id);
      chk({name, " result"}, result, exp_res);
      chk({name, " overflow"}, overflow, exp_ovf);
      chk({name, " gnt_done"}, gnt, exp_gnt);
      chk({name, " busy_done"}, busy, 1);
      req = 2'b00;
      @(negedge clk);
      chk({name, " idle_busy"}, busy, 0);
      chk({name, " idle_gnt"}, gnt, 0);
      chk({name, " idle_done"}, done, 0);
      chk({name, " result_hold"}, result, exp_res);
   endtask

   initial begin
      int done_t[4];
      int done_i[4];
      int done_r[4];
      int nd;
      bit got;

      reset = 1'b1;
      req   = 2'b00;
      n0    = '0;
      n1    = '0;

      vecs[0] = '{2'b01, 5'd11, 5'd0,  1'b0, 6'd55, 1'b0};
      vecs[1] = '{2'b10, 5'd0,  5'd12, 1'b1, 6'd2,  1'b1};
      vecs[2] = '{2'b01, 5'd0,  5'd7,  1'b0, 6'd0,  1'b0};
      vecs[3] = '{2'b10, 5'd3,  5'd31, 1'b1, 6'd17, 1'b1};
      vecs[4] = '{2'b01, 5'd1,  5'd9,  1'b0, 6'd0,  1'b0};
      vecs[5] = '{2'b11, 5'd8,  5'd2,  1'b1, 6'd1,  1'b0};
      vecs[6] = '{2'b11, 5'd8,  5'd2,  1'b0, 6'd28, 1'b0};

      repeat (2) @(negedge clk);
      chk("rst gnt", gnt, 0);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst done_id", done_id, 0);
      chk("rst result", result, 0);
      chk("rst overflow", overflow, 0);
      reset = 1'b0;

      foreach (vecs[i])
         run_op($sformatf("vec%0d", i), vecs[i].req, vecs[i].n0, vecs[i].n1,
                vecs[i].exp_id, vecs[i].exp_res, vecs[i].exp_ovf);

      // Contention: both held, pointer alternates; spacing is n_served + 2.
      do_reset();
      @(negedge clk);
      req = 2'b11;
      n0  = 5'd3;
      n1  = 5'd4;
      nd  = 0;
      for (int k = 1; k <= 60 && nd < 4; k++) begin
         @(negedge clk);
         if (done) begin
            done_t[nd] = k;
            done_i[nd] = int'(done_id);
            done_r[nd] = int'(result);
            nd++;
         end
      end
      req = 2'b00;
      chk("rr done_count", nd, 4);
      if (nd == 4) begin
         chk("rr first_latency", done_t[0], 4);
         for (int j = 0; j < 4; j++) begin
            chk($sformatf("rr id%0d", j), done_i[j], j % 2);
            chk($sformatf("rr res%0d", j), done_r[j], (j % 2) ? 6 : 3);
         end
         for (int j = 1; j < 4; j++)
            chk($sformatf("rr gap%0d", j), done_t[j] - done_t[j-1], (j % 2) ? 6 : 5);
      end
      @(negedge clk);

      // Request drop mid-RUN: operation still completes.
      @(negedge clk);
      req = 2'b01;
      n0  = 5'd5;
      repeat (3) @(negedge clk);
      req = 2'b00;
      chk("drop busy", busy, 1);
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         if (done) got = 1'b1;
         else @(negedge clk);
      end
      chk("drop done_seen", got, 1);
      chk("drop result", result, 10);
      chk("drop done_id", done_id, 0);
      @(negedge clk);

      // Reset mid-RUN with pointer at 1 and a nonzero held result.
      do_reset();
      run_op("pre", 2'b01, 5'd2, 5'd0, 1'b0, 6'd1, 1'b0);
      @(negedge clk);
      req = 2'b10;
      n1  = 5'd11;
      repeat (4) @(negedge clk);
      chk("mid busy", busy, 1);
      reset = 1'b1;
      @(negedge clk);
      chk("rstmid gnt", gnt, 0);
      chk("rstmid busy", busy, 0);
      chk("rstmid done", done, 0);
      chk("rstmid result", result, 0);
      chk("rstmid overflow", overflow, 0);
      req   = 2'b00;
      reset = 1'b0;
      run_op("ptr_after_rst", 2'b11, 5'd2, 5'd3, 1'b0, 6'd1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
